load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the core pipeline and drives the word-addressed data memory (MemRead, MemWrite, address, write_data, read_data).
- Performs byte/halfword extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores; rejects misaligned and out-of-range accesses.
- Sits between the execute stage and data_memory.

Parameters:
- W, 32, data and address width
- N, 5, log2 of memory depth in words; valid byte addresses are 0 .. 4*2**N-1

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  pipeline request present
- req_ready  output  1  unit can accept a request
- req_op  input  4  {is_store, funct3}; funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101 (stores use 000/001/010)
- req_addr  input  W  byte address
- req_wdata  input  W  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  pipeline accepts response
- resp_rdata  output  W  load result (0 for stores and errors)
- resp_err  output  1  misaligned, out-of-range or illegal op
- mem_address  output  W  byte address to memory, bits [1:0] forced 00
- mem_read  output  1  MemRead
- mem_write  output  1  MemWrite
- mem_write_data  output  W  word to store
- mem_read_data  input  W  memory read data, combinational from mem_address/mem_read

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (rst=0, async): state=IDLE, all outputs 0 except req_ready=1; captured request registers cleared.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata and check:
  - Illegal: load funct3 not in {000,001,010,100,101}, or store funct3 > 010.
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00.
  - Out of range: addr >= 4*2**N.
  - Error -> RESP with resp_err=1, no memory strobe.
  - Load or sub-word store -> READ.
  - SW -> WRITE.
- READ: mem_read=1 for exactly one cycle, mem_address=latched addr. Capture mem_read_data at the clock edge.
  - Load -> RESP with extracted data: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
  - Sub-word store -> WRITE.
- WRITE: mem_write=1 for exactly one cycle.
  - mem_write_data = req_wdata for SW.
  - For SB/SH: captured word with the selected lane replaced by req_wdata[7:0] / [15:0].
  - -> RESP.
- RESP: resp_valid=1, held stable until resp_ready=1; on that edge -> IDLE.
- Handshake: req_ready=0 and mem_read=mem_write=0 in every state except as listed above. mem_read and mem_write are never both 1.
- Latency, accept edge to first resp_valid cycle:
  - loads 2 cycles
  - SW 2 cycles
  - SB/SH 3 cycles
  - errors 1 cycle
- Throughput: one request in flight; the next is accepted no earlier than the cycle after the resp handshake.
- Reset mid-operation: state returns to IDLE immediately. A WRITE aborted before its clock edge leaves memory untouched; no partial response.
- Address wrap: none; overflow is caught by the range check.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t {IDLE, READ, WRITE, RESP}
  - function is_legal_op
- Sub-module lsu_data_align (combinational): inputs word, byte offset, funct3, store data. Outputs extended load value and merged store word. It is unit-testable standalone.

Test Plan:
- Memory word 0x8 = 0x80F1_7F02. LB at 0x8 -> 0x0000_0002; LB at 0xA -> 0xFFFF_FFF1; LBU at 0xB -> 0x0000_0080; LH at 0xA -> 0xFFFF_80F1. Each has resp_valid 2 cycles after accept.
- SB 0xAB to 0x9 with word 0x1122_3344 -> exactly one mem_read cycle, then one mem_write with 0x1122_AB44; resp at cycle 3.
- SW 0xDEAD_BEEF to 0x7C (last word, N=5), then LW 0x7C -> returns 0xDEAD_BEEF. No mem_read during the SW.
- LW 0x6 and SH 0x3 -> resp_err=1, resp_rdata=0, 1-cycle latency, mem_read=mem_write=0 throughout. LW 0x80 -> resp_err=1 (out of range).
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata are stable and req_ready=0. A req_valid during the stall is not accepted.
- Assert rst=0 during the WRITE state of an SB -> outputs clear asynchronously, memory word unchanged, unit returns to IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  // op = {is_store, funct3}; stores have no unsigned variants
  function automatic logic is_legal_op(input logic [3:0] op);
    if (op[3]) return op[2:0] inside {F3_B, F3_H, F3_W};
    return op[2:0] inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory port bundle of the load/store unit.
interface load_store_unit_if #(parameter int W = 32);

  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_rdata;
  logic         resp_err;
  logic [W-1:0] mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_write_data;
  logic [W-1:0] mem_read_data;

  // slave: the unit itself; master: the pipeline plus memory around it
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_write_data
  );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic: extends loaded bytes/halfwords and merges
// sub-word store data into a previously read word.
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   offset,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] store_data,
  output logic [W-1:0] load_data,
  output logic [W-1:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word[{offset, 3'b000} +: 8];
    lane_h    = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{(W-8){lane_b[7]}}, lane_b};
      F3_H:    load_data = {{(W-16){lane_h[15]}}, lane_h};
      F3_BU:   load_data = {{(W-8){1'b0}}, lane_b};
      F3_HU:   load_data = {{(W-16){1'b0}}, lane_h};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B:    store_word[{offset, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    store_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight, read-modify-write for
// sub-word stores, error response for illegal/misaligned/out-of-range access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_t   state, state_nxt;
  logic [3:0]   op_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic [W-1:0] word_q;
  logic         err_q;
  logic         req_err;
  logic         accept;
  logic [W-1:0] load_data;
  logic [W-1:0] store_word;

  assign accept  = (state == IDLE) && bus.req_valid;
  // Any address bit at or above N+2 means the byte address is past the last word
  assign req_err = !is_legal_op(bus.req_op)
                || is_misaligned(bus.req_op[2:0], bus.req_addr[1:0])
                || ((bus.req_addr >> (N + 2)) != '0);

  lsu_data_align #(.W(W)) u_align (
    .word       (word_q),
    .offset     (addr_q[1:0]),
    .funct3     (op_q[2:0]),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
      end
      if (state == READ) word_q <= bus.mem_read_data;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.resp_err       = 1'b0;
    bus.mem_address    = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                                      state_nxt = RESP;
          else if (bus.req_op[3] && bus.req_op[2:0] == F3_W) state_nxt = WRITE;
          else                                              state_nxt = READ;
        end
      end
      READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {addr_q[W-1:2], 2'b00};
        state_nxt       = op_q[3] ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = {addr_q[W-1:2], 2'b00};
        bus.mem_write_data = store_word;
        state_nxt          = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (err_q || op_q[3]) ? '0 : load_data;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-addressed memory model plus a scoreboard of
// expected responses, one task per scenario.
module tb_load_store_unit;

  localparam logic [3:0] OP_LB  = 4'b0000, OP_LH  = 4'b0001, OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100, OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000, OP_SH  = 4'b1001, OP_SW  = 4'b1010;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [31:0] mem [0:31];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  load_store_unit_if #(.W(32)) bus ();

  load_store_unit #(.W(32), .N(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en)            mem[poke_idx] <= poke_val;
    else if (bus.mem_write) mem[bus.mem_address[6:2]] <= bus.mem_write_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[4:0]; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one request and return what the DUT did until resp_valid appears.
  task automatic drive_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int nrd, output int nwr, output logic [31:0] wd, output logic both);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; wd = '0; both = 1'b0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin nwr++; wd = bus.mem_write_data; end
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
    end
    n_checks++;
    if ({bus.mem_address, bus.resp_rdata, bus.mem_write_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h rdata %h wdata %h want 0",
               bus.mem_address, bus.resp_rdata, bus.mem_write_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_loads();
    logic [3:0]  ops   [7] = '{OP_LB, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
    logic [31:0] addrs [7] = '{32'h8, 32'hA, 32'hB, 32'hA, 32'hA, 32'h8, 32'h9};
    logic [31:0] vals  [7] = '{32'h0000_0002, 32'hFFFF_FFF1, 32'h0000_0080, 32'hFFFF_80F1,
                               32'h0000_80F1, 32'h80F1_7F02, 32'h0000_007F};
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    poke(2, 32'h80F1_7F02);
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{rdata: vals[i], err: 1'b0, lat: 2, nrd: 1, nwr: 0, wd: 32'h0});
      drive_txn(ops[i], addrs[i], 32'h0, rdata, err, lat, nrd, nwr, wd, both);
      e = sb.pop_front();
      n_checks++;
      if (rdata !== e.rdata || err !== e.err) begin
        n_fail++;
        $display("FAIL load_data[%0d]: rdata %h err %b want %h err %b", i, rdata, err, e.rdata, e.err);
      end
      n_checks++;
      if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
        n_fail++;
        $display("FAIL load_timing[%0d]: lat %0d rd %0d wr %0d want lat %0d rd %0d wr %0d",
                 i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_sub_store();
    logic [3:0]  ops   [2] = '{OP_SB, OP_SH};
    logic [31:0] addrs [2] = '{32'h9, 32'hA};
    logic [31:0] wdat  [2] = '{32'hFFFF_FFAB, 32'h1234_CAFE};
    logic [31:0] merged[2] = '{32'h1122_AB44, 32'hCAFE_AB44};
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    poke(2, 32'h1122_3344);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3, nrd: 1, nwr: 1, wd: merged[i]});
      drive_txn(ops[i], addrs[i], wdat[i], rdata, err, lat, nrd, nwr, wd, both);
      e = sb.pop_front();
      n_checks++;
      if (wd !== e.wd || rdata !== e.rdata || err !== e.err) begin
        n_fail++;
        $display("FAIL substore_data[%0d]: wdata %h rdata %h err %b want %h 0 0", i, wd, rdata, err, e.wd);
      end
      n_checks++;
      if (lat != e.lat || nrd != e.nrd || nwr != e.nwr || both) begin
        n_fail++;
        $display("FAIL substore_timing[%0d]: lat %0d rd %0d wr %0d both %b want lat %0d rd 1 wr 1",
                 i, lat, nrd, nwr, both, e.lat);
      end
      n_checks++;
      if (mem[2] !== e.wd) begin
        n_fail++;
        $display("FAIL substore_mem[%0d]: mem %h want %h", i, mem[2], e.wd);
      end
    end
  endtask

  task automatic test_word_store();
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2, nrd: 0, nwr: 1, wd: 32'hDEAD_BEEF});
    drive_txn(OP_SW, 32'h7C, 32'hDEAD_BEEF, rdata, err, lat, nrd, nwr, wd, both);
    e = sb.pop_front();
    n_checks++;
    if (wd !== e.wd || err !== e.err || lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
      n_fail++;
      $display("FAIL sw_last: wdata %h err %b lat %0d rd %0d wr %0d want %h 0 2 0 1",
               wd, err, lat, nrd, nwr, e.wd);
    end
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, lat: 2, nrd: 1, nwr: 0, wd: 32'h0});
    drive_txn(OP_LW, 32'h7C, 32'h0, rdata, err, lat, nrd, nwr, wd, both);
    e = sb.pop_front();
    n_checks++;
    if (rdata !== e.rdata || err !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL lw_last: rdata %h err %b lat %0d want %h 0 2", rdata, err, lat, e.rdata);
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops   [6] = '{OP_LW, OP_SH, OP_LW, 4'b0011, 4'b1011, OP_SW};
    logic [31:0] addrs [6] = '{32'h6, 32'h3, 32'h80, 32'h8, 32'h8, 32'h100};
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1, nrd: 0, nwr: 0, wd: 32'h0});
      drive_txn(ops[i], addrs[i], 32'h5555_AAAA, rdata, err, lat, nrd, nwr, wd, both);
      e = sb.pop_front();
      n_checks++;
      if (rdata !== e.rdata || err !== e.err || lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
        n_fail++;
        $display("FAIL error_resp[%0d]: rdata %h err %b lat %0d rd %0d wr %0d want 0 1 1 0 0",
                 i, rdata, err, lat, nrd, nwr);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    poke(4, 32'h0BAD_F00D);
    bus.resp_ready = 1'b0;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, lat: 2, nrd: 1, nwr: 0, wd: 32'h0});
    drive_txn(OP_LW, 32'h10, 32'h0, rdata, err, lat, nrd, nwr, wd, both);
    e = sb.pop_front();
    n_checks++;
    if (rdata !== e.rdata || lat != e.lat) begin
      n_fail++;
      $display("FAIL stall_first: rdata %h lat %0d want %h 2", rdata, lat, e.rdata);
    end
    bus.req_valid = 1'b1; bus.req_op = OP_LW; bus.req_addr = 32'h7C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || bus.req_ready !== 1'b0 ||
          bus.mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid %b rdata %h req_ready %b mem_read %b want 1 %h 0 0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready, bus.mem_read, e.rdata);
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: req_ready %b resp_valid %b mem_read %b want 1 0 0",
               bus.req_ready, bus.resp_valid, bus.mem_read);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rdata, wd;
    logic        err, both;
    int          lat, nrd, nwr;
    exp_t        e;
    poke(3, 32'h5566_7788);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_SB; bus.req_addr = 32'hD; bus.req_wdata = 32'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_write_state: mem_write %b want 1", bus.mem_write);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.mem_write, bus.mem_read, bus.resp_valid} !== 4'b1000 ||
        bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready/wr/rd/valid %b addr %h wdata %h want 1000 0 0",
               {bus.req_ready, bus.mem_write, bus.mem_read, bus.resp_valid},
               bus.mem_address, bus.mem_write_data);
    end
    @(negedge clk);
    n_checks++;
    if (mem[3] !== 32'h5566_7788) begin
      n_fail++;
      $display("FAIL midrst_mem: mem %h want 55667788", mem[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: req_ready %b resp_valid %b want 1 0", bus.req_ready, bus.resp_valid);
    end
    sb.push_back('{rdata: 32'h5566_7788, err: 1'b0, lat: 2, nrd: 1, nwr: 0, wd: 32'h0});
    drive_txn(OP_LW, 32'hC, 32'h0, rdata, err, lat, nrd, nwr, wd, both);
    e = sb.pop_front();
    n_checks++;
    if (rdata !== e.rdata || err !== e.err || lat != e.lat) begin
      n_fail++;
      $display("FAIL midrst_reload: rdata %h err %b lat %0d want %h 0 2", rdata, err, lat, e.rdata);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_loads();
    test_sub_store();
    test_word_store();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
